if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage that drives the instruction ROM address port and consumes the returned word.
- Holds the program counter and buffers fetched {pc, inst} pairs in a DEPTH-entry FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the buffer and reloads the PC.
- The ROM read is combinational: the instruction arrives in the same cycle as the address.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
DEPTH, 2, FIFO entries (power of two, 2..8)
NOP_INST, 32'h00000013, value driven on out_inst when the FIFO is empty

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetching allowed; 0 = PC holds and nothing is pushed
imem_addr  output  32  ROM instruction address, combinationally equal to pc
imem_inst  input  32  ROM instruction word for imem_addr, valid in the same cycle
redirect_valid  input  1  flush the FIFO and load redirect_pc
redirect_pc  input  32  new PC; bits [1:0] are ignored (forced to 0)
out_valid  output  1  FIFO head is valid
out_ready  input  1  decode accepts the head this cycle
out_pc  output  32  PC of the head entry
out_inst  output  32  instruction of the head entry
fetch_cnt  output  32  count of instructions pushed since reset, wraps at 2^32

Behaviour:
- One clock, rst asynchronous active-high.
- On rst assertion, immediately:
  - pc=RESET_PC, FIFO count=0, rd_ptr=wr_ptr=0, fetch_cnt=0
  - all entries cleared to {pc=0, inst=NOP_INST}
  - out_valid=0, out_pc=0, out_inst=NOP_INST
- Reset released mid-operation: normal fetching starts at RESET_PC on the first rising edge after deassertion. No stale entry survives.
- imem_addr = pc at all times, including reset.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
  - When the FIFO is full, a simultaneous pop frees the slot in the same cycle.
- On push:
  - entry[wr_ptr] <= {pc, imem_inst}; wr_ptr advances modulo DEPTH.
  - pc <= pc+4, 32-bit wrap: 32'hFFFFFFFC -> 32'h00000000.
  - fetch_cnt <= fetch_cnt+1.
- On pop: rd_ptr advances modulo DEPTH.
- Count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Redirect has priority over everything:
  - count<=0, rd_ptr<=wr_ptr<=0
  - pc <= {redirect_pc[31:2], 2'b00}
  - no push that cycle
  - A pop handshake completing in the same cycle is legal but has no further effect; the entry is discarded with the rest.
- First instruction after a redirect:
  - fetched the next cycle (when fetch_en=1)
  - out_valid rises one cycle after that
  - redirect-to-out_valid latency = 2 cycles
- Fetch latency: pc presented in cycle N, entry visible at the output in cycle N+1 when the FIFO was empty.
- Sustained throughput: 1 instruction/cycle when out_ready=1 and fetch_en=1.
- Outputs come from registered FIFO state:
  - out_valid = (count!=0)
  - out_pc/out_inst = entry[rd_ptr] when valid, else 0/NOP_INST
  - no combinational path from out_ready to out_*
- Stability: while out_valid=1 and out_ready=0, out_pc/out_inst hold stable unless redirect_valid=1.
- fetch_en=0: no push, pc holds. Pops continue to drain the FIFO.
- FIFO full with out_ready=0: no push, pc holds, imem_addr shows the next unfetched pc.
- fetch_cnt never resets except on rst; a redirect does not clear it.

Test Plan:
1. Reset then fetch_en=1, out_ready=1, ROM holding 100002b7, 02100313, 0062a023, 0000006f -> out_valid rises at cycle 1; out_pc 0,4,8,C on consecutive cycles; out_inst equals those words in order; fetch_cnt=4 after 4 pushes.
2. out_ready=0 from reset with fetch_en=1 -> after 2 cycles count=2 (DEPTH=2); pc and imem_addr hold at 8; out_pc=0 and out_inst=100002b7 stay stable; raising out_ready then gives a push+pop in one cycle with count staying at 2.
3. Redirect with redirect_pc=32'h0000000F while the FIFO is full -> next cycle out_valid=0 and pc=C; the following cycle out_pc=C and out_inst=0000006f; the discarded entries never appear.
4. pc preloaded by redirect to 32'hFFFFFFFC, out_ready=1 -> out_pc sequence FFFFFFFC then 00000000; no X on any output.
5. Assert rst asynchronously between edges with 2 entries buffered -> out_valid=0, out_inst=00000013, fetch_cnt=0 immediately without waiting for a clock edge; after release, first out_pc=RESET_PC.
6. fetch_en=0 for 3 cycles mid-stream with out_ready=1 -> FIFO drains to out_valid=0, pc unchanged, fetch_cnt unchanged; resuming continues at the held pc.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: drives the ROM address from the PC and buffers fetched
// {pc, inst} pairs in a small FIFO presented to decode over a valid/ready handshake.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      pc, pc_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0] count, count_next;

  logic [31:0] entry_pc   [DEPTH];
  logic [31:0] entry_inst [DEPTH];

  logic pop;
  logic push;
  logic has_room;

  assign imem_addr = pc;

  // Outputs depend only on registered FIFO state, never on out_ready.
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? entry_pc[rd_ptr]   : 32'h0000_0000;
  assign out_inst  = out_valid ? entry_inst[rd_ptr] : NOP_INST;

  always_comb begin
    pop         = out_valid & out_ready;
    has_room    = (count < FULL_CNT) | pop;
    push        = fetch_en & ~redirect_valid & has_room;

    pc_next     = pc;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;

    if (redirect_valid) begin
      // A pop completing alongside a redirect is swallowed by the flush.
      pc_next     = {redirect_pc[31:2], 2'b00};
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc + 32'd4;
        wr_ptr_next = wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_cnt <= 32'h0000_0000;
    end else begin
      pc     <= pc_next;
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  // Entries are not cleared on redirect; the zeroed count hides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc[i]   <= 32'h0000_0000;
        entry_inst[i] <= NOP_INST;
      end
    end else if (push) begin
      entry_pc[wr_ptr]   <= pc;
      entry_inst[wr_ptr] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a queue-based reference model feeds a scoreboard that a
// negedge monitor drains, covering the directed scenarios and then random traffic.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_cnt;

  int vectors    = 0;
  int miscompares = 0;

  entry_t      sbQueue[$];
  entry_t      monHead;
  logic        monEnable;
  logic        expValid;
  logic [31:0] expAddr;
  logic [31:0] expCnt;
  logic        pendingFlush;

  int          mCount;
  logic [31:0] mPc;
  logic [31:0] mFetchCnt;

  if_fetch_queue #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h1000_02b7;
      32'h0000_0004: return 32'h0210_0313;
      32'h0000_0008: return 32'h0062_a023;
      32'h0000_000C: return 32'h0000_006f;
      default:       return (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always_comb imem_inst = romWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    sbQueue.delete();
    pendingFlush = 1'b0;
    mCount       = 0;
    mPc          = RESET_PC;
    mFetchCnt    = 32'h0;
  endtask

  // Called at posedge+1: drives one cycle of inputs, advances the model, waits out the cycle.
  task automatic applyStimulus(input logic fe, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    logic pop;
    logic push;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;

    expValid  = (mCount != 0);
    expAddr   = mPc;
    expCnt    = mFetchCnt;
    monEnable = 1'b1;

    pop = expValid && rdy;
    if (rv) begin
      mCount       = 0;
      mPc          = {rpc[31:2], 2'b00};
      pendingFlush = 1'b1;
    end else begin
      push = fe && ((mCount < DEPTH) || pop);
      if (push) begin
        sbQueue.push_back('{pc: mPc, inst: romWord(mPc)});
        mPc       = mPc + 32'd4;
        mFetchCnt = mFetchCnt + 32'd1;
      end
      mCount = mCount + (push ? 1 : 0) - (pop ? 1 : 0);
    end

    @(posedge clk);
    if (pendingFlush) begin
      sbQueue.delete();
      pendingFlush = 1'b0;
    end
    #1;
  endtask

  // Synchronous-looking reset used between scenarios; also checks the reset state.
  task automatic doReset();
    monEnable = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_inst", out_inst, NOP_INST);
    checkOutput("reset_pc_out", out_pc, 32'h0);
    checkOutput("reset_addr", imem_addr, RESET_PC);
    checkOutput("reset_fetch_cnt", fetch_cnt, 32'h0);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    rst            = 1'b0;
  endtask

  // Monitor: compares the DUT against the scoreboard head and pops on a model handshake.
  always @(negedge clk) begin
    if (monEnable && !rst) begin
      checkOutput("out_valid", {31'h0, out_valid}, {31'h0, expValid});
      checkOutput("imem_addr", imem_addr, expAddr);
      checkOutput("fetch_cnt", fetch_cnt, expCnt);
      if (expValid) begin
        if (sbQueue.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL scoreboard_empty: got out_pc %h, expected a queued entry", out_pc);
        end else begin
          monHead = sbQueue[0];
          checkOutput("out_pc", out_pc, monHead.pc);
          checkOutput("out_inst", out_inst, monHead.inst);
          if (out_ready) void'(sbQueue.pop_front());
        end
      end else begin
        checkOutput("idle_out_pc", out_pc, 32'h0);
        checkOutput("idle_out_inst", out_inst, NOP_INST);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    monEnable      = 1'b0;
    expValid       = 1'b0;
    expAddr        = RESET_PC;
    expCnt         = 32'h0;
    resetModel();

    // Streaming fetch of the small program at full throughput.
    doReset();
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure from reset, then a push+pop while full, then redirect while full.
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_000F, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

    // PC wrap across the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // fetch_en low mid-stream drains the FIFO with the PC held.
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset between edges with two entries buffered.
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    #3;
    monEnable = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async_rst_inst", out_inst, NOP_INST);
    checkOutput("async_rst_fetch_cnt", fetch_cnt, 32'h0);
    checkOutput("async_rst_addr", imem_addr, RESET_PC);
    resetModel();
    @(posedge clk);
    #1;
    fetch_en  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic        fe;
      logic        rv;
      logic        rdy;
      logic [31:0] rpc;
      fe  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom();
      applyStimulus(fe, rv, rpc, rdy);
    end

    monEnable = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
